// File: rtl/ttt_pkg.sv
// ttt_pkg: shared types, cell/winner codes and board helpers for the tic-tac-toe sequencer
package ttt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        P_WAIT,
        P_CHECK,
        C_REQ,
        C_CHECK,
        GAME_OVER
    } state_t;

    localparam logic [1:0] CELL_EMPTY  = 2'b00;
    localparam logic [1:0] CELL_PLAYER = 2'b01;
    localparam logic [1:0] CELL_CPU    = 2'b10;

    localparam logic [1:0] WIN_NONE   = 2'b00;
    localparam logic [1:0] WIN_PLAYER = 2'b01;
    localparam logic [1:0] WIN_CPU    = 2'b10;
    localparam logic [1:0] WIN_DRAW   = 2'b11;

    // Returned by first_empty when the board has no free cell
    localparam logic [3:0] NO_CELL = 4'hF;

    localparam logic [3:0] WIN_LINES [8][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    // Out-of-range indices read as 11 so they never look empty
    function automatic logic [1:0] cell_at(input logic [17:0] m, input logic [3:0] idx);
        cell_at = 2'b11;
        for (int i = 0; i < 9; i++)
            if (idx == 4'(i)) cell_at = m[2*i +: 2];
    endfunction

    // Out-of-range indices leave the board untouched
    function automatic logic [17:0] set_cell(input logic [17:0] m, input logic [3:0] idx,
                                             input logic [1:0] code);
        set_cell = m;
        for (int i = 0; i < 9; i++)
            if (idx == 4'(i)) set_cell[2*i +: 2] = code;
    endfunction

    function automatic logic has_line(input logic [17:0] m, input logic [1:0] code);
        has_line = 1'b0;
        for (int l = 0; l < 8; l++)
            if (cell_at(m, WIN_LINES[l][0]) == code &&
                cell_at(m, WIN_LINES[l][1]) == code &&
                cell_at(m, WIN_LINES[l][2]) == code)
                has_line = 1'b1;
    endfunction

    function automatic logic board_full(input logic [17:0] m);
        board_full = 1'b1;
        for (int i = 0; i < 9; i++)
            if (m[2*i +: 2] == CELL_EMPTY) board_full = 1'b0;
    endfunction

    // Scans downwards so the lowest empty index is the one left standing
    function automatic logic [3:0] first_empty(input logic [17:0] m);
        first_empty = NO_CELL;
        for (int i = 8; i >= 0; i--)
            if (m[2*i +: 2] == CELL_EMPTY) first_empty = 4'(i);
    endfunction

endpackage

// File: rtl/line_checker.sv
// line_checker: combinational board evaluation shared by the player and CPU check states
module line_checker
    import ttt_pkg::*;
(
    input  logic [17:0] board,
    output logic        player_line,
    output logic        cpu_line,
    output logic        full,
    output logic [3:0]  first_free
);

    assign player_line = has_line(board, CELL_PLAYER);
    assign cpu_line    = has_line(board, CELL_CPU);
    assign full        = board_full(board);
    assign first_free  = first_empty(board);

endmodule

// File: rtl/turn_sequencer.sv
// turn_sequencer: owns the board, alternates player/CPU turns and reports win or draw
module turn_sequencer
    import ttt_pkg::*;
#(
    parameter logic [31:0] TURN_CYCLES = 32'd50_000_000,
    parameter logic [3:0]  MAX_RETRY   = 4'd8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        cpu_first,
    input  logic        move_valid,
    input  logic [3:0]  move_cell,
    input  logic [3:0]  rnd_cell,
    input  logic        rnd_found,
    output logic        rnd_enable,
    output logic [17:0] game_matrix,
    output logic        player_turn,
    output logic        move_accept,
    output logic        move_reject,
    output logic        turn_timeout,
    output logic [1:0]  winner,
    output logic        game_over
);

    state_t      state, state_n;
    logic [17:0] board_n;
    logic [1:0]  winner_n;
    logic [31:0] tcnt, tcnt_n;
    logic [3:0]  retry, retry_n;
    logic        accept_n, reject_n, timeout_n;
    logic        player_line, cpu_line, full;
    logic [3:0]  first_free;
    logic        move_ok, rnd_ok;

    line_checker u_line_checker (
        .board      (game_matrix),
        .player_line(player_line),
        .cpu_line   (cpu_line),
        .full       (full),
        .first_free (first_free)
    );

    assign move_ok = (move_cell <= 4'd8) && (cell_at(game_matrix, move_cell) == CELL_EMPTY);
    assign rnd_ok  = (rnd_cell <= 4'd8) && (cell_at(game_matrix, rnd_cell) == CELL_EMPTY);

    // Next-state, board update and pulse decisions; start overrides everything
    always_comb begin
        state_n   = state;
        board_n   = game_matrix;
        winner_n  = winner;
        tcnt_n    = '0;
        retry_n   = '0;
        accept_n  = 1'b0;
        reject_n  = 1'b0;
        timeout_n = 1'b0;
        if (start) begin
            board_n  = '0;
            winner_n = WIN_NONE;
            state_n  = cpu_first ? C_REQ : P_WAIT;
        end else begin
            case (state)
                P_WAIT: begin
                    tcnt_n = tcnt + 32'd1;
                    if (move_valid && move_ok) begin
                        board_n  = set_cell(game_matrix, move_cell, CELL_PLAYER);
                        accept_n = 1'b1;
                        state_n  = P_CHECK;
                    end else begin
                        reject_n = move_valid;
                        if (tcnt == TURN_CYCLES - 32'd1) begin
                            timeout_n = 1'b1;
                            state_n   = C_REQ;
                        end
                    end
                end
                P_CHECK: begin
                    if (player_line) begin
                        winner_n = WIN_PLAYER;
                        state_n  = GAME_OVER;
                    end else if (full) begin
                        winner_n = WIN_DRAW;
                        state_n  = GAME_OVER;
                    end else begin
                        state_n = C_REQ;
                    end
                end
                C_REQ: begin
                    retry_n = retry;
                    if (retry == MAX_RETRY) begin
                        board_n = set_cell(game_matrix, first_free, CELL_CPU);
                        state_n = C_CHECK;
                    end else if (rnd_enable && rnd_found) begin
                        if (rnd_ok) begin
                            board_n = set_cell(game_matrix, rnd_cell, CELL_CPU);
                            state_n = C_CHECK;
                        end else begin
                            retry_n = (retry == 4'hF) ? retry : retry + 4'd1;
                        end
                    end
                end
                C_CHECK: begin
                    if (cpu_line) begin
                        winner_n = WIN_CPU;
                        state_n  = GAME_OVER;
                    end else if (full) begin
                        winner_n = WIN_DRAW;
                        state_n  = GAME_OVER;
                    end else begin
                        state_n = P_WAIT;
                    end
                end
                default: ;
            endcase
        end
    end

    // State, board, counters and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            game_matrix  <= '0;
            winner       <= WIN_NONE;
            tcnt         <= '0;
            retry        <= '0;
            rnd_enable   <= 1'b0;
            player_turn  <= 1'b0;
            move_accept  <= 1'b0;
            move_reject  <= 1'b0;
            turn_timeout <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            state        <= state_n;
            game_matrix  <= board_n;
            winner       <= winner_n;
            tcnt         <= tcnt_n;
            retry        <= retry_n;
            // Request rises one cycle after entering C_REQ, so a restart always shows a gap
            rnd_enable   <= !start && (state == C_REQ) && (state_n == C_REQ);
            player_turn  <= (state_n == P_WAIT);
            move_accept  <= accept_n;
            move_reject  <= reject_n;
            turn_timeout <= timeout_n;
            game_over    <= (state_n == GAME_OVER);
        end
    end

endmodule

// File: tb/tb_turn_sequencer.sv
// tb_turn_sequencer: directed game scenarios checked each cycle against a behavioural game model
module tb_turn_sequencer;

    localparam int TC = 16;
    localparam int MR = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cpu_first = 1'b0;
    logic        move_valid = 1'b0;
    logic [3:0]  move_cell = '0;
    logic [3:0]  rnd_cell = '0;
    logic        rnd_found = 1'b0;
    logic        rnd_enable;
    logic [17:0] game_matrix;
    logic        player_turn, move_accept, move_reject, turn_timeout, game_over;
    logic [1:0]  winner;

    int n_cmp = 0;
    int n_bad = 0;

    turn_sequencer #(.TURN_CYCLES(32'(TC)), .MAX_RETRY(4'(MR))) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cpu_first   (cpu_first),
        .move_valid  (move_valid),
        .move_cell   (move_cell),
        .rnd_cell    (rnd_cell),
        .rnd_found   (rnd_found),
        .rnd_enable  (rnd_enable),
        .game_matrix (game_matrix),
        .player_turn (player_turn),
        .move_accept (move_accept),
        .move_reject (move_reject),
        .turn_timeout(turn_timeout),
        .winner      (winner),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Phases: 0 idle, 1 human to move, 2 judging human move, 3 CPU to move, 4 judging CPU move, 5 finished
    int mb[9];
    int mw, ph, oph, mt, mr;
    bit e_en, e_pt, e_acc, e_rej, e_to, e_go;
    int lines[8] = '{12, 345, 678, 36, 147, 258, 48, 246};

    function automatic bit line_of(int who);
        for (int l = 0; l < 8; l++)
            if (mb[lines[l] / 100] == who && mb[(lines[l] / 10) % 10] == who && mb[lines[l] % 10] == who)
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [17:0] model_board();
        logic [17:0] v = '0;
        for (int i = 0; i < 9; i++) v = v | (18'(mb[i]) << (2 * i));
        return v;
    endfunction

    task automatic judge(input int who);
        int empties = 0;
        for (int i = 0; i < 9; i++) if (mb[i] == 0) empties++;
        if (line_of(who)) begin mw = who; ph = 5; end
        else if (empties == 0) begin mw = 3; ph = 5; end
        else ph = (who == 1) ? 3 : 1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) mb[i] = 0;
            mw = 0; ph = 0; mt = 0; mr = 0;
            e_en = 0; e_acc = 0; e_rej = 0; e_to = 0;
        end else begin
            oph = ph;
            e_acc = 0; e_rej = 0; e_to = 0;
            if (start) begin
                for (int i = 0; i < 9; i++) mb[i] = 0;
                mw = 0;
                ph = cpu_first ? 3 : 1;
            end else if (ph == 1) begin
                if (move_valid && move_cell <= 8 && mb[move_cell] == 0) begin
                    mb[move_cell] = 1; e_acc = 1; ph = 2;
                end else begin
                    e_rej = move_valid;
                    if (mt == TC - 1) begin e_to = 1; ph = 3; end
                end
            end else if (ph == 2) begin
                judge(1);
            end else if (ph == 3) begin
                if (mr == MR) begin
                    int lo = 9;
                    for (int i = 8; i >= 0; i--) if (mb[i] == 0) lo = i;
                    if (lo < 9) mb[lo] = 2;
                    ph = 4;
                end else if (e_en && rnd_found) begin
                    if (rnd_cell <= 8 && mb[rnd_cell] == 0) begin mb[rnd_cell] = 2; ph = 4; end
                    else mr = mr + 1;
                end
            end else if (ph == 4) begin
                judge(2);
            end
            mt = (!start && oph == 1 && ph == 1) ? mt + 1 : 0;
            if (start || ph != 3) mr = 0;
            e_en = !start && oph == 3 && ph == 3;
        end
        e_pt = (ph == 1);
        e_go = (ph == 5);
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        n_cmp++;
        if ({game_matrix, winner, rnd_enable, player_turn, move_accept, move_reject, turn_timeout, game_over} !==
            {model_board(), 2'(mw), e_en, e_pt, e_acc, e_rej, e_to, e_go}) begin
            n_bad++;
            $display("FAIL cycle t=%0t got mat=%h win=%b en=%b pt=%b acc=%b rej=%b to=%b go=%b want mat=%h win=%b en=%b pt=%b acc=%b rej=%b to=%b go=%b",
                     $time, game_matrix, winner, rnd_enable, player_turn, move_accept, move_reject, turn_timeout, game_over,
                     model_board(), 2'(mw), e_en, e_pt, e_acc, e_rej, e_to, e_go);
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic do_start(input bit cf);
        start = 1'b1; cpu_first = cf;
        @(negedge clk);
        start = 1'b0; cpu_first = 1'b0;
    endtask

    task automatic wait_turn();
        int n = 0;
        while (!player_turn && n < 100) begin @(negedge clk); n++; end
        chk("wait_player_turn", 32'(player_turn), 32'd1);
    endtask

    task automatic wait_en();
        int n = 0;
        while (!rnd_enable && n < 100) begin @(negedge clk); n++; end
        chk("wait_rnd_enable", 32'(rnd_enable), 32'd1);
    endtask

    task automatic wait_over();
        int n = 0;
        while (!game_over && n < 100) begin @(negedge clk); n++; end
        chk("wait_game_over", 32'(game_over), 32'd1);
    endtask

    task automatic pmove(input int c);
        wait_turn();
        move_valid = 1'b1; move_cell = 4'(c);
        @(negedge clk);
        move_valid = 1'b0;
    endtask

    task automatic cgive(input int c);
        wait_en();
        rnd_found = 1'b1; rnd_cell = 4'(c);
        @(negedge clk);
        rnd_found = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("reset_matrix", 32'(game_matrix), 32'h0);
        chk("reset_winner", 32'(winner), 32'h0);
        chk("reset_outputs", {27'd0, rnd_enable, player_turn, move_accept, move_reject, game_over}, 32'h0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Player wins on the top row
        do_start(1'b0);
        chk("start_player_turn", 32'(player_turn), 32'd1);
        pmove(0);
        chk("first_accept", 32'(move_accept), 32'd1);
        cgive(4);
        pmove(1);
        cgive(5);
        pmove(2);
        wait_over();
        chk("row_win_matrix", 32'(game_matrix), 32'h00A15);
        chk("row_win_winner", 32'(winner), 32'd1);
        chk("model_row_win", 32'(model_board()), 32'h00A15);
        move_valid = 1'b1; move_cell = 4'd3;
        @(negedge clk);
        move_valid = 1'b0;
        chk("over_no_pulse", {30'd0, move_accept, move_reject}, 32'd0);
        chk("over_board_held", 32'(game_matrix), 32'h00A15);

        // Rejections: CPU-owned cell, then out-of-range index
        do_start(1'b0);
        pmove(0);
        cgive(4);
        pmove(4);
        chk("reject_occupied", 32'(move_reject), 32'd1);
        pmove(9);
        chk("reject_range", 32'(move_reject), 32'd1);
        chk("reject_board", 32'(game_matrix), 32'h00201);
        chk("reject_still_turn", 32'(player_turn), 32'd1);

        // Timeout after TC idle cycles
        do_start(1'b0);
        n = 0;
        while (player_turn && n < 40) begin @(negedge clk); n++; end
        chk("timeout_cycles", 32'(n), 32'(TC));
        chk("timeout_pulse", 32'(turn_timeout), 32'd1);
        @(negedge clk);
        chk("timeout_enable", 32'(rnd_enable), 32'd1);
        chk("timeout_single", 32'(turn_timeout), 32'd0);

        // Retry exhaustion: occupied, invalid, occupied -> fallback to cell 1
        do_start(1'b0);
        pmove(0);
        cgive(0);
        cgive(9);
        cgive(0);
        chk("retry_not_yet", 32'(game_matrix), 32'h00001);
        @(negedge clk);
        chk("fallback_board", 32'(game_matrix), 32'h00009);
        chk("fallback_drop_en", 32'(rnd_enable), 32'd0);

        // Draw: final player move at cell 8 fills the board with no line
        do_start(1'b0);
        pmove(0); cgive(4); pmove(2); cgive(1); pmove(3); cgive(5); pmove(7); cgive(6); pmove(8);
        wait_over();
        chk("draw_matrix", 32'(game_matrix), 32'h16A59);
        chk("draw_winner", 32'(winner), 32'd3);
        chk("model_draw", 32'(model_board()), 32'h16A59);

        // Full board that also completes the main diagonal: the line wins
        do_start(1'b0);
        pmove(0); cgive(1); pmove(2); cgive(3); pmove(4); cgive(5); pmove(7); cgive(6); pmove(8);
        wait_over();
        chk("fullwin_matrix", 32'(game_matrix), 32'h16999);
        chk("fullwin_winner", 32'(winner), 32'd1);

        // Restart during a pending CPU request
        do_start(1'b0);
        pmove(0);
        wait_en();
        do_start(1'b1);
        chk("restart_board", 32'(game_matrix), 32'h0);
        chk("restart_en_gap", 32'(rnd_enable), 32'd0);
        @(negedge clk);
        chk("restart_en_back", 32'(rnd_enable), 32'd1);
        cgive(3);
        wait_turn();
        chk("cpu_first_board", 32'(game_matrix), 32'h00080);

        // Asynchronous reset mid-game
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_board", 32'(game_matrix), 32'h0);
        chk("async_reset_en", 32'(rnd_enable), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {30'd0, player_turn, game_over}, 32'd0);
        do_start(1'b0);
        chk("start_after_reset", 32'(player_turn), 32'd1);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
